// File: rtl/exec_arbiter.sv
// exec_arbiter: round-robin owner selection for a shared single-command
// execution unit. It issues start pulses, watches done/err against a timeout,
// retries failed attempts through a recovery cycle, and returns ack/fail to
// the owning requester.
module exec_arbiter #(
  parameter int TIMEOUT   = 8,
  parameter int MAX_RETRY = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       done,
  input  logic       err,
  output logic [1:0] gnt,
  output logic       start,
  output logic [1:0] ack,
  output logic [1:0] fail,
  output logic       busy
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);
  localparam logic [RW-1:0] RETRY_ONE  = RW'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RECOV = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    gnt_q, gnt_d;
  logic          lp_q, lp_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [RW-1:0] retry_cnt_q, retry_cnt_d;
  logic          result_ok_q, result_ok_d;
  logic          attempt_failed;

  // Next-state logic: owner choice, attempt timing, retry budget and result.
  always_comb begin
    state_d        = state_q;
    gnt_d          = gnt_q;
    lp_d           = lp_q;
    timer_d        = timer_q;
    retry_cnt_d    = retry_cnt_q;
    result_ok_d    = result_ok_q;
    attempt_failed = 1'b0;

    case (state_q)
      IDLE: begin
        gnt_d = 2'b00;
        if (req != 2'b00) begin
          if (req == 2'b11) begin
            gnt_d = lp_q ? 2'b01 : 2'b10;
          end else begin
            gnt_d = req;
          end
          retry_cnt_d = '0;
          state_d     = ISSUE;
        end
      end

      ISSUE: begin
        timer_d = TIMER_LOAD;
        state_d = WAIT;
      end

      WAIT: begin
        timer_d        = (timer_q != '0) ? (timer_q - TIMER_ONE) : '0;
        attempt_failed = err || (!done && (timer_q <= TIMER_ONE));
        if (done && !err) begin
          result_ok_d = 1'b1;
          state_d     = RESP;
        end else if (attempt_failed) begin
          if (retry_cnt_q < RETRY_MAX) begin
            retry_cnt_d = retry_cnt_q + RETRY_ONE;
            state_d     = RECOV;
          end else begin
            result_ok_d = 1'b0;
            state_d     = RESP;
          end
        end
      end

      RECOV: begin
        state_d = ISSUE;
      end

      RESP: begin
        lp_d    = gnt_q[1];
        gnt_d   = 2'b00;
        state_d = IDLE;
      end

      default: begin
        gnt_d   = 2'b00;
        state_d = IDLE;
      end
    endcase
  end

  // State and bookkeeping registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= 2'b00;
      lp_q        <= 1'b1;
      timer_q     <= '0;
      retry_cnt_q <= '0;
      result_ok_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      lp_q        <= lp_d;
      timer_q     <= timer_d;
      retry_cnt_q <= retry_cnt_d;
      result_ok_q <= result_ok_d;
    end
  end

  assign gnt   = gnt_q;
  assign start = (state_q == ISSUE);
  assign ack   = ((state_q == RESP) && result_ok_q)  ? gnt_q : 2'b00;
  assign fail  = ((state_q == RESP) && !result_ok_q) ? gnt_q : 2'b00;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_exec_arbiter.sv
// Directed self-checking bench for exec_arbiter. A second instance with
// MAX_RETRY=0 covers the no-retry collision case.
module tb_exec_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req, req1;
  logic       done, err, done1, err1;
  logic [1:0] gnt, ack, fail, gnt1, ack1, fail1;
  logic       start, busy, start1, busy1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  exec_arbiter #(.TIMEOUT(8), .MAX_RETRY(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done), .err(err),
    .gnt(gnt), .start(start), .ack(ack), .fail(fail), .busy(busy)
  );

  exec_arbiter #(.TIMEOUT(8), .MAX_RETRY(0)) dut_nr (
    .clk(clk), .rst_n(rst_n), .req(req1), .done(done1), .err(err1),
    .gnt(gnt1), .start(start1), .ack(ack1), .fail(fail1), .busy(busy1)
  );

  // Advance to the next falling edge, where outputs are sampled and inputs driven.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req = 2'b00; done = 1'b0; err = 1'b0;
    req1 = 2'b00; done1 = 1'b0; err1 = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = 2'b00; done = 1'b0; err = 1'b0;
    req1 = 2'b00; done1 = 1'b0; err1 = 1'b0;
    #2;
    total++; if (gnt !== 2'b00) begin bad++; $display("[TB] FAIL reset_gnt: got %b want 00", gnt); end
    total++; if (start !== 1'b0) begin bad++; $display("[TB] FAIL reset_start: got %b want 0", start); end
    total++; if (ack !== 2'b00 || fail !== 2'b00) begin bad++; $display("[TB] FAIL reset_ackfail: got %b/%b want 00/00", ack, fail); end
    total++; if (busy !== 1'b0 || busy1 !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b/%b want 0/0", busy, busy1); end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    total++; if (busy !== 1'b0 || gnt !== 2'b00) begin bad++; $display("[TB] FAIL reset_idle_after_release: got busy=%b gnt=%b want 0 00", busy, gnt); end
  endtask

  task automatic test_single_success();
    apply_reset();
    req = 2'b01;
    tick();
    total++; if (gnt !== 2'b01 || start !== 1'b1 || busy !== 1'b1) begin bad++; $display("[TB] FAIL single_issue: got gnt=%b start=%b busy=%b want 01 1 1", gnt, start, busy); end
    tick();
    total++; if (start !== 1'b0 || ack !== 2'b00) begin bad++; $display("[TB] FAIL single_wait1: got start=%b ack=%b want 0 00", start, ack); end
    tick();
    done = 1'b1;
    tick();
    total++; if (ack !== 2'b01 || fail !== 2'b00 || gnt !== 2'b01) begin bad++; $display("[TB] FAIL single_resp: got ack=%b fail=%b gnt=%b want 01 00 01", ack, fail, gnt); end
    done = 1'b0;
    req  = 2'b00;
    tick();
    total++; if (ack !== 2'b00 || busy !== 1'b0 || gnt !== 2'b00) begin bad++; $display("[TB] FAIL single_idle: got ack=%b busy=%b gnt=%b want 00 0 00", ack, busy, gnt); end
  endtask

  task automatic test_round_robin();
    logic [1:0] order [4];
    order[0] = 2'b01; order[1] = 2'b10; order[2] = 2'b01; order[3] = 2'b10;
    apply_reset();
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (gnt !== order[i] || start !== 1'b1) begin bad++; $display("[TB] FAIL rr_grant%0d: got gnt=%b start=%b want %b 1", i, gnt, start, order[i]); end
      tick();
      done = 1'b1;
      tick();
      total++; if (ack !== order[i] || fail !== 2'b00) begin bad++; $display("[TB] FAIL rr_ack%0d: got ack=%b fail=%b want %b 00", i, ack, fail, order[i]); end
      done = 1'b0;
      req  = req & ~order[i];
      tick();
      total++; if (busy !== 1'b0 || ack !== 2'b00) begin bad++; $display("[TB] FAIL rr_idle%0d: got busy=%b ack=%b want 0 00", i, busy, ack); end
      req = (i == 3) ? 2'b00 : 2'b11;
    end
    tick();
  endtask

  task automatic test_retry();
    apply_reset();
    req = 2'b01;
    tick();
    total++; if (start !== 1'b1) begin bad++; $display("[TB] FAIL retry_start1: got %b want 1", start); end
    tick();
    err = 1'b1;
    tick();
    total++; if (start !== 1'b0 || busy !== 1'b1 || ack !== 2'b00 || fail !== 2'b00) begin bad++; $display("[TB] FAIL retry_recov: got start=%b busy=%b ack=%b fail=%b want 0 1 00 00", start, busy, ack, fail); end
    err = 1'b0;
    tick();
    total++; if (start !== 1'b1 || gnt !== 2'b01) begin bad++; $display("[TB] FAIL retry_start2: got start=%b gnt=%b want 1 01", start, gnt); end
    tick();
    done = 1'b1;
    tick();
    total++; if (ack !== 2'b01 || fail !== 2'b00) begin bad++; $display("[TB] FAIL retry_ack: got ack=%b fail=%b want 01 00", ack, fail); end
    done = 1'b0;
    req  = 2'b00;
    tick();
  endtask

  task automatic test_timeout_exhaust();
    int busy_cnt = 0;
    int starts = 0;
    int start_pos [3];
    int fail_cnt = 0;
    int fail_pos = -1;
    int ack_cnt = 0;
    logic [1:0] fail_val = 2'b00;
    start_pos[0] = -1; start_pos[1] = -1; start_pos[2] = -1;
    apply_reset();
    req = 2'b10;
    for (int cyc = 0; cyc < 60; cyc++) begin
      tick();
      if (busy === 1'b1) busy_cnt++;
      if (start === 1'b1) begin
        if (starts < 3) start_pos[starts] = cyc;
        starts++;
      end
      if (ack !== 2'b00) ack_cnt++;
      if (fail !== 2'b00) begin
        fail_cnt++;
        fail_val = fail;
        fail_pos = cyc;
        req = 2'b00;
      end
    end
    total++; if (starts != 3) begin bad++; $display("[TB] FAIL to_starts: got %0d want 3", starts); end
    total++; if (start_pos[0] != 0 || start_pos[1] != 10 || start_pos[2] != 20) begin bad++; $display("[TB] FAIL to_start_spacing: got %0d,%0d,%0d want 0,10,20", start_pos[0], start_pos[1], start_pos[2]); end
    total++; if (busy_cnt != 30) begin bad++; $display("[TB] FAIL to_busy_cycles: got %0d want 30", busy_cnt); end
    total++; if (fail_cnt != 1 || fail_val !== 2'b10 || fail_pos != 29) begin bad++; $display("[TB] FAIL to_fail: got cnt=%0d val=%b pos=%0d want 1 10 29", fail_cnt, fail_val, fail_pos); end
    total++; if (ack_cnt != 0) begin bad++; $display("[TB] FAIL to_no_ack: got %0d want 0", ack_cnt); end
  endtask

  task automatic test_collision();
    apply_reset();
    req = 2'b01;
    tick();
    tick();
    done = 1'b1;
    err  = 1'b1;
    tick();
    total++; if (ack !== 2'b00 || fail !== 2'b00 || busy !== 1'b1 || start !== 1'b0) begin bad++; $display("[TB] FAIL col_retry_recov: got ack=%b fail=%b busy=%b start=%b want 00 00 1 0", ack, fail, busy, start); end
    done = 1'b0;
    err  = 1'b0;
    tick();
    total++; if (start !== 1'b1) begin bad++; $display("[TB] FAIL col_retry_start: got %b want 1", start); end
    tick();
    done = 1'b1;
    tick();
    total++; if (ack !== 2'b01) begin bad++; $display("[TB] FAIL col_retry_ack: got %b want 01", ack); end
    done = 1'b0;
    req  = 2'b00;
    tick();

    req1 = 2'b01;
    tick();
    total++; if (gnt1 !== 2'b01 || start1 !== 1'b1) begin bad++; $display("[TB] FAIL col_nr_issue: got gnt=%b start=%b want 01 1", gnt1, start1); end
    tick();
    done1 = 1'b1;
    err1  = 1'b1;
    tick();
    total++; if (fail1 !== 2'b01 || ack1 !== 2'b00) begin bad++; $display("[TB] FAIL col_nr_resp: got fail=%b ack=%b want 01 00", fail1, ack1); end
    done1 = 1'b0;
    err1  = 1'b0;
    req1  = 2'b00;
    tick();
    total++; if (busy1 !== 1'b0 || fail1 !== 2'b00) begin bad++; $display("[TB] FAIL col_nr_idle: got busy=%b fail=%b want 0 00", busy1, fail1); end
    done1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (busy1 !== 1'b0 || start1 !== 1'b0 || gnt1 !== 2'b00 || ack1 !== 2'b00 || fail1 !== 2'b00) begin bad++; $display("[TB] FAIL col_stray_done%0d: got busy=%b start=%b gnt=%b ack=%b fail=%b want all 0", i, busy1, start1, gnt1, ack1, fail1); end
    end
    done1 = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    apply_reset();
    req = 2'b01;
    tick();
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = 2'b00;
    tick();
    req = 2'b11;
    tick();
    total++; if (gnt !== 2'b10) begin bad++; $display("[TB] FAIL rst_pre_gnt: got %b want 10", gnt); end
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (gnt !== 2'b00 || start !== 1'b0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_async: got gnt=%b start=%b busy=%b want 00 0 0", gnt, start, busy); end
    total++; if (ack !== 2'b00 || fail !== 2'b00) begin bad++; $display("[TB] FAIL rst_async_ackfail: got %b/%b want 00/00", ack, fail); end
    tick();
    rst_n = 1'b1;
    tick();
    total++; if (gnt !== 2'b01 || start !== 1'b1 || ack !== 2'b00 || fail !== 2'b00) begin bad++; $display("[TB] FAIL rst_post_gnt: got gnt=%b start=%b ack=%b fail=%b want 01 1 00 00", gnt, start, ack, fail); end
    tick();
    done = 1'b1;
    tick();
    total++; if (ack !== 2'b01 || fail !== 2'b00) begin bad++; $display("[TB] FAIL rst_post_ack: got ack=%b fail=%b want 01 00", ack, fail); end
    done = 1'b0;
    req  = 2'b00;
    tick();
  endtask

  // Overall run bound so the bench always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scenario sequence.
  initial begin
    test_reset();
    test_single_success();
    test_round_robin();
    test_retry();
    test_timeout_exhaust();
    test_collision();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
